// File: rtl/hps_reset_sequencer.sv
// hps_reset_sequencer
//
// Fabric-side reset controller for the HPS. Debounces the cold and warm
// push-buttons, arbitrates them against fabric reset sources (watchdog,
// debug) by fixed priority, drives exactly one FPGA-to-HPS reset request
// for HOLD_CYCLES, then follows the HPS-to-FPGA reset handshake (low, then
// high again) to completion or timeout. A lockout window follows every
// completed sequence so bouncing buttons cannot retrigger immediately.
//
// Ports
//   clk_clk                in   system clock (only clock)
//   reset_reset_n          in   synchronous active-low reset
//   cold_btn_n             in   cold-reset push-button, async, active-low
//   warm_btn_n             in   warm-reset push-button, async, active-low
//   wdt_expire             in   1-cycle pulse, requests a warm reset
//   debug_req              in   1-cycle pulse, requests a debug reset
//   h2f_reset_n            in   HPS-to-FPGA reset, async, 2-flop synchronised
//   f2h_cold_reset_req_n   out  HPS cold reset request, active-low
//   f2h_warm_reset_req_n   out  HPS warm reset request, active-low
//   f2h_debug_reset_req_n  out  HPS debug reset request, active-low
//   stm_hwevents[27:0]     out  STM event pulses:
//                               [0] cold, [1] warm, [2] debug request issued,
//                               [3] handshake timeout, [4] sequence done
//   busy                   out  high whenever the sequencer is not idle
//   last_cause[1:0]        out  00 none, 01 cold, 10 warm, 11 debug
//   timeout_err            out  sticky handshake-timeout flag

module hps_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 1024,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cold_btn_n,
  input  logic        warm_btn_n,
  input  logic        wdt_expire,
  input  logic        debug_req,
  input  logic        h2f_reset_n,
  output logic        f2h_cold_reset_req_n,
  output logic        f2h_warm_reset_req_n,
  output logic        f2h_debug_reset_req_n,
  output logic [27:0] stm_hwevents,
  output logic        busy,
  output logic [1:0]  last_cause,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_COLD  = 2'b01;
  localparam logic [1:0] CAUSE_WARM  = 2'b10;
  localparam logic [1:0] CAUSE_DEBUG = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ASSERT    = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_DONE      = 3'd4,
    S_LOCKOUT   = 3'd5
  } state_t;

  // Counters stop at their terminal values instead of wrapping.
  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // One-hot select of the request line / STM event bit for a cause code.
  function automatic logic [2:0] cause_onehot(input logic [1:0] c);
    case (c)
      CAUSE_COLD:  return 3'b001;
      CAUSE_WARM:  return 3'b010;
      CAUSE_DEBUG: return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

  // Index 0 is the cold button, index 1 the warm button.
  logic [1:0]       btn_raw;
  logic [1:0]       btn_sync_p0;
  logic [1:0]       btn_sync_p1;
  logic [CNT_W-1:0] deb_cnt [2];
  logic [1:0]       deb_lvl_p2;
  logic [1:0]       deb_lvl_p3;
  logic             h2f_sync_p0;
  logic             h2f_sync_p1;

  logic             cold_evt;
  logic             warm_evt;
  logic [1:0]       win_cause;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cur_cause;
  logic             cold_pend;
  logic [2:0]       req_n;
  logic [4:0]       stm_evt;

  assign btn_raw = {warm_btn_n, cold_btn_n};

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      btn_sync_p0 <= 2'b11;
      btn_sync_p1 <= 2'b11;
      deb_lvl_p2  <= 2'b11;
      deb_lvl_p3  <= 2'b11;
      h2f_sync_p0 <= 1'b1;
      h2f_sync_p1 <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      // p0 -> p1: two-flop synchronisers for the asynchronous inputs
      btn_sync_p0 <= btn_raw;
      btn_sync_p1 <= btn_sync_p0;
      h2f_sync_p0 <= h2f_reset_n;
      h2f_sync_p1 <= h2f_sync_p0;

      // p1 -> p2: debounce; the level drops only after DEBOUNCE_CYCLES
      // consecutive low samples and recovers on the first high sample
      for (int i = 0; i < 2; i++) begin
        if (btn_sync_p1[i]) begin
          deb_cnt[i]    <= '0;
          deb_lvl_p2[i] <= 1'b1;
        end else if (deb_lvl_p2[i]) begin
          if (deb_cnt[i] >= DEB_LAST) begin
            deb_lvl_p2[i] <= 1'b0;
          end else begin
            deb_cnt[i] <= inc_sat(deb_cnt[i]);
          end
        end
      end

      // p2 -> p3: delayed level for falling-edge detection
      deb_lvl_p3 <= deb_lvl_p2;
    end
  end

  // A held button yields a single event: only the debounced falling edge.
  assign cold_evt = deb_lvl_p3[0] & ~deb_lvl_p2[0];
  assign warm_evt = (deb_lvl_p3[1] & ~deb_lvl_p2[1]) | wdt_expire;

  // Fixed priority: pending/new cold, then warm, then debug.
  always_comb begin
    win_cause = CAUSE_NONE;
    if (cold_pend || cold_evt) begin
      win_cause = CAUSE_COLD;
    end else if (warm_evt) begin
      win_cause = CAUSE_WARM;
    end else if (debug_req) begin
      win_cause = CAUSE_DEBUG;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cur_cause   <= CAUSE_NONE;
      cold_pend   <= 1'b0;
      req_n       <= 3'b111;
      stm_evt     <= '0;
      last_cause  <= CAUSE_NONE;
      timeout_err <= 1'b0;
    end else begin
      stm_evt <= '0;

      case (state)
        S_IDLE: begin
          if (win_cause != CAUSE_NONE) begin
            state        <= S_ASSERT;
            cnt          <= HOLD_LAST;
            req_n        <= ~cause_onehot(win_cause);
            stm_evt[2:0] <= cause_onehot(win_cause);
            last_cause   <= win_cause;
            cur_cause    <= win_cause;
            // When a pending cold is serviced, a fresh cold event in the
            // same cycle stays latched for the next sequence.
            cold_pend    <= cold_pend & cold_evt;
          end
        end

        S_ASSERT: begin
          if (cnt == '0) begin
            req_n <= 3'b111;
            if (cur_cause == CAUSE_DEBUG) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT_LOW;
              cnt   <= TMO_LAST;
            end
          end else begin
            cnt <= dec_sat(cnt);
          end
        end

        S_WAIT_LOW: begin
          // An edge seen on the terminal count still wins over the timeout.
          if (!h2f_sync_p1) begin
            state <= S_WAIT_HIGH;
            cnt   <= TMO_LAST;
          end else if (cnt == '0) begin
            timeout_err <= 1'b1;
            stm_evt[3]  <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= dec_sat(cnt);
          end
        end

        S_WAIT_HIGH: begin
          if (h2f_sync_p1) begin
            state <= S_DONE;
          end else if (cnt == '0) begin
            timeout_err <= 1'b1;
            stm_evt[3]  <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= dec_sat(cnt);
          end
        end

        S_DONE: begin
          stm_evt[4] <= 1'b1;
          cnt        <= HOLD_LAST;
          state      <= S_LOCKOUT;
        end

        S_LOCKOUT: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= dec_sat(cnt);
          end
        end

        default: begin
          state <= S_IDLE;
          req_n <= 3'b111;
        end
      endcase

      // Outside IDLE only cold survives; warm and debug are dropped.
      if (state != S_IDLE && cold_evt) begin
        cold_pend <= 1'b1;
      end
    end
  end

  assign f2h_cold_reset_req_n  = req_n[0];
  assign f2h_warm_reset_req_n  = req_n[1];
  assign f2h_debug_reset_req_n = req_n[2];
  assign stm_hwevents          = {23'd0, stm_evt};
  assign busy                  = (state != S_IDLE);

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Testbench for hps_reset_sequencer with small timing parameters.
module tb_hps_reset_sequencer;

  localparam int DEB = 4;
  localparam int H   = 8;
  localparam int T   = 32;
  localparam int CW  = 26;

  logic        clk = 1'b0;
  logic        rstn, cold_b, warm_b, wdt, dbg, h2f;
  logic        cold_n, warm_n, dbg_n;
  logic [27:0] stm;
  logic        busy;
  logic [1:0]  lc;
  logic        terr;

  always #5 clk = ~clk;

  hps_reset_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (H),
    .TIMEOUT_CYCLES (T),
    .CNT_W          (CW)
  ) dut (
    .clk_clk              (clk),
    .reset_reset_n        (rstn),
    .cold_btn_n           (cold_b),
    .warm_btn_n           (warm_b),
    .wdt_expire           (wdt),
    .debug_req            (dbg),
    .h2f_reset_n          (h2f),
    .f2h_cold_reset_req_n (cold_n),
    .f2h_warm_reset_req_n (warm_n),
    .f2h_debug_reset_req_n(dbg_n),
    .stm_hwevents         (stm),
    .busy                 (busy),
    .last_cause           (lc),
    .timeout_err          (terr)
  );

  int    total = 0;
  int    bad   = 0;
  int    n     = 0;
  string phase = "init";

  // reference model state
  int crun = 0, wrun = 0;
  int cq[$];
  int wq[$];
  bit cpend = 0;
  int next_free = 0;
  bit sv = 0;
  bit seq_done = 0;
  int s_st = 0, kind = 0, d_t = 0, t_t = 0;
  bit m_terr = 0;
  int m_last = 0;
  int pl = 0, ph = 0;
  int hps_mode = 1;

  // observation tallies per phase
  int lowc[3];
  int sc[5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic clear_tally();
    for (int i = 0; i < 3; i++) lowc[i] = 0;
    for (int i = 0; i < 5; i++) sc[i] = 0;
  endtask

  // Plans the HPS handshake and derives when the sequence ends.
  task automatic start_seq(input int k);
    int a, b, r, e, mode;
    sv = 1; s_st = n; kind = k; m_last = k;
    pl = 0; ph = 0;
    if (k == 3) begin
      seq_done = 1;
      d_t = n + H;
    end else begin
      mode = hps_mode;
      a = 5; b = 10;
      if (mode == 0) begin
        r = $urandom_range(0, 7);
        if (r == 0) mode = 2;
        else if (r == 1) begin mode = 1; a = $urandom_range(0, 5); b = $urandom_range(T + 1, T + 3); end
        else begin mode = 1; a = $urandom_range(0, T - 2); b = $urandom_range(1, T); end
      end
      if (mode == 2) begin
        seq_done = 0;
        t_t = n + H + T;
      end else begin
        pl = n + H + a;
        ph = pl + b;
        e  = pl + 2;
        if (ph + 2 > e + T) begin
          seq_done = 0;
          t_t = e + T;
        end else begin
          seq_done = 1;
          d_t = ph + 2;
        end
      end
    end
    next_free = seq_done ? d_t + H + 2 : t_t + 1;
  endtask

  task automatic model_step();
    bit ce, we, de;
    int k;
    if (!rstn) begin
      crun = 0; wrun = 0;
      cq.delete(); wq.delete();
      cpend = 0; sv = 0; m_terr = 0; m_last = 0;
      next_free = n + 1;
      pl = 0; ph = 0;
    end else begin
      if (!cold_b) begin crun++; if (crun == DEB) cq.push_back(n + 3); end
      else crun = 0;
      if (!warm_b) begin wrun++; if (wrun == DEB) wq.push_back(n + 3); end
      else wrun = 0;
      ce = 0; we = wdt; de = dbg;
      if (cq.size() > 0 && cq[0] == n) begin ce = 1; void'(cq.pop_front()); end
      if (wq.size() > 0 && wq[0] == n) begin we = 1; void'(wq.pop_front()); end
      if (n >= next_free) begin
        k = 0;
        if (cpend) begin k = 1; cpend = ce; end
        else if (ce) k = 1;
        else if (we) k = 2;
        else if (de) k = 3;
        if (k != 0) start_seq(k);
      end else if (ce) begin
        cpend = 1;
      end
      if (sv && !seq_done && n == t_t) m_terr = 1;
    end
  endtask

  task automatic compare();
    logic [2:0]  er;
    logic [27:0] es;
    logic        eb;
    er = 3'b111; es = '0; eb = 1'b0;
    if (sv) begin
      if (n >= s_st && n <= s_st + H - 1) er[kind-1] = 1'b0;
      if (n == s_st) es[kind-1] = 1'b1;
      if (seq_done) begin
        if (n == d_t + 1) es[4] = 1'b1;
        eb = (n >= s_st && n <= d_t + H);
      end else begin
        if (n == t_t) es[3] = 1'b1;
        eb = (n >= s_st && n < t_t);
      end
    end
    check({phase, ":req_n"}, {29'd0, dbg_n, warm_n, cold_n}, {29'd0, er});
    check({phase, ":stm"}, {4'd0, stm}, {4'd0, es});
    check({phase, ":busy"}, {31'd0, busy}, {31'd0, eb});
    check({phase, ":last_cause"}, {30'd0, lc}, m_last);
    check({phase, ":timeout_err"}, {31'd0, terr}, {31'd0, m_terr});
    if (!cold_n) lowc[0]++;
    if (!warm_n) lowc[1]++;
    if (!dbg_n)  lowc[2]++;
    for (int i = 0; i < 5; i++) if (stm[i]) sc[i]++;
  endtask

  task automatic tick();
    h2f = !(n >= pl && n < ph);
    model_step();
    @(posedge clk);
    #1;
    compare();
    n++;
    wdt = 1'b0;
    dbg = 1'b0;
  endtask

  initial begin
    int tgt, chold, whold;
    rstn = 1'b0; cold_b = 1'b1; warm_b = 1'b1; wdt = 1'b0; dbg = 1'b0; h2f = 1'b1;
    hps_mode = 1;
    clear_tally();

    phase = "reset";
    repeat (3) tick();
    rstn = 1'b1;
    repeat (3) tick();

    phase = "cold_short";
    clear_tally();
    cold_b = 1'b0; repeat (3) tick();
    cold_b = 1'b1; repeat (20) tick();
    check("cold_short_low_cycles", lowc[0], 0);

    phase = "cold_hold";
    clear_tally();
    cold_b = 1'b0; repeat (10) tick();
    cold_b = 1'b1; repeat (60) tick();
    check("cold_hold_low_cycles", lowc[0], H);
    check("cold_hold_stm0_pulses", sc[0], 1);
    check("cold_hold_last_cause", {30'd0, lc}, 1);

    phase = "warm_wdt";
    clear_tally();
    wdt = 1'b1; tick();
    repeat (60) tick();
    check("warm_low_cycles", lowc[1], H);
    check("warm_done_pulses", sc[4], 1);
    check("warm_timeout_err", {31'd0, terr}, 0);

    phase = "prio_same_cycle";
    clear_tally();
    cold_b = 1'b0;
    tgt = n + DEB + 2;
    while (n < tgt) tick();
    wdt = 1'b1; tick();
    cold_b = 1'b1;
    repeat (60) tick();
    check("prio_cold_low", lowc[0], H);
    check("prio_warm_dropped", lowc[1], 0);

    phase = "cold_in_wait_high";
    clear_tally();
    wdt = 1'b1; tick();
    repeat (16) tick();
    cold_b = 1'b0; repeat (6) tick();
    cold_b = 1'b1; repeat (100) tick();
    check("pend_cold_low", lowc[0], H);
    check("pend_warm_low", lowc[1], H);

    phase = "timeout";
    clear_tally();
    hps_mode = 2;
    wdt = 1'b1; tick();
    repeat (50) tick();
    check("timeout_pulses", sc[3], 1);
    check("timeout_flag", {31'd0, terr}, 1);
    hps_mode = 1;
    dbg = 1'b1; tick();
    repeat (30) tick();
    check("timeout_sticky", {31'd0, terr}, 1);

    phase = "debug";
    clear_tally();
    dbg = 1'b1; tick();
    repeat (30) tick();
    check("debug_low_cycles", lowc[2], H);
    check("debug_done_pulses", sc[4], 1);
    check("debug_last_cause", {30'd0, lc}, 3);

    phase = "reset_mid";
    clear_tally();
    wdt = 1'b1; tick();
    repeat (3) tick();
    rstn = 1'b0; tick();
    check("reset_mid_last_cause", {30'd0, lc}, 0);
    rstn = 1'b1;
    repeat (60) tick();
    check("reset_mid_warm_low", lowc[1], 4);

    phase = "random";
    hps_mode = 0;
    chold = 0; whold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (chold == 0) begin cold_b = ($urandom_range(0, 3) != 0); chold = $urandom_range(1, 12); end
      else chold--;
      if (whold == 0) begin warm_b = ($urandom_range(0, 3) != 0); whold = $urandom_range(1, 12); end
      else whold--;
      wdt  = ($urandom_range(0, 39) == 0);
      dbg  = ($urandom_range(0, 39) == 0);
      rstn = ($urandom_range(0, 599) != 0);
      tick();
    end
    rstn = 1'b1; cold_b = 1'b1; warm_b = 1'b1;
    repeat (150) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
